// File: rtl/byte_serializer_if.sv
// rtl/byte_serializer_if.sv - handshake and serial-output bundle for byte_serializer
//
// Signals:
//   din          parallel word from upstream (WIDTH bits)
//   din_valid    din holds a word to transmit
//   din_ready    serializer accepts din on this edge
//   sout         serial data bit
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  first bit of a frame
//   frame_last   final bit (data or parity) of a frame
// Modports: master = upstream / consumer side, slave = serializer side.

interface byte_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_last;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_last
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        output frame_start,
        output frame_last
    );
endinterface

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel-to-serial stage with optional parity bit
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1 = din[WIDTH-1] sent first, 0 = din[0] sent first
//   PARITY     0 = none, 1 = even parity bit appended, 2 = odd parity bit appended
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    byte_serializer_if.slave: din/din_valid/din_ready handshake in,
//          sout/sout_valid/frame_start/frame_last serial stream out

module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    byte_serializer_if.slave   bus
);

    localparam int L  = WIDTH + ((PARITY != 0) ? 1 : 0);
    localparam int CW = $clog2(L);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic             par;
    logic             par_in;
    logic             at_last;
    logic             ready;
    logic             accept;
    logic             head;
    logic             shifting;

    assign shifting = (state == SHIFT);
    assign at_last  = (cnt == LAST);

    // Ready on the final bit too, so a new word can follow with no idle gap.
    assign ready  = (state == IDLE) || (shifting && at_last);
    assign accept = bus.din_valid && ready;

    assign par_in = (PARITY == 2) ? ~^bus.din : ^bus.din;

    assign head         = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign sreg_shifted = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SHIFT;
        end else if (shifting && at_last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            sreg <= '0;
            par  <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            sreg <= bus.din;
            par  <= par_in;
        end else if (shifting) begin
            sreg <= sreg_shifted;
            // Wrap to zero when the frame ends without a follow-on word.
            cnt  <= at_last ? '0 : cnt + 1'b1;
        end
    end

    // With parity enabled the last count slot carries the parity bit
    // instead of a data bit.
    assign bus.sout        = shifting ? (((PARITY != 0) && at_last) ? par : head) : 1'b0;
    assign bus.sout_valid  = shifting;
    assign bus.frame_start = shifting && (cnt == '0);
    assign bus.frame_last  = shifting && at_last;
    assign bus.din_ready   = ready;

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Parallel-to-serial stage that sits directly downstream of the 8-bit shift_reg and consumes its dout bus.
- Accepts one WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clk, with an optional parity bit appended.
- Supports back-to-back frames with no idle gap between them.
- Feeds the serial link or bit-level consumer further down the datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- PARITY, 0, 0 = none; 1 = even parity bit appended; 2 = odd parity bit appended.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- din  input  WIDTH  parallel word from upstream shift_reg dout.
- din_valid  input  1  din holds a word to transmit.
- din_ready  output  1  block accepts din on this edge; combinational from state.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high during the first bit of each frame.
- frame_last  output  1  high during the final bit (data or parity) of each frame.

Behaviour:
- Frame length L = WIDTH + (PARITY != 0 ? 1 : 0). Bit counter cnt is ceil(log2(L)) bits wide.
- States: IDLE, SHIFT.
- Reset (rst_n=0 at an edge), regardless of state:
  - state=IDLE, cnt=0, shift register=0, parity reg=0.
  - Outputs: sout=0, sout_valid=0, frame_start=0, frame_last=0, din_ready=1 once rst_n is high.
  - din_valid is ignored while rst_n=0.
  - A frame in progress is abandoned, not completed.
- din_ready = (state==IDLE) || (state==SHIFT && cnt==L-1).
- Accept = din_valid && din_ready at a rising edge. On accept:
  - Load the shift register with din; cnt<=0; state<=SHIFT.
  - Parity reg <= ^din for PARITY=1, or ~^din for PARITY=2.
- Latency: the first bit appears on sout in the cycle immediately after the accepting edge. Bits then follow on consecutive cycles with no gaps.
- In SHIFT:
  - For cnt < WIDTH: sout = the current head bit of the shift register (MSB when MSB_FIRST=1, LSB otherwise). The register shifts by one at each edge, zero-filled.
  - For cnt == WIDTH (only when PARITY != 0): sout = parity reg.
  - cnt increments at each edge while cnt < L-1.
- At an edge with cnt == L-1:
  - With accept: reload, cnt<=0, stay in SHIFT. This is seamless streaming — frame_last of frame N is immediately followed by frame_start of frame N+1.
  - Without accept: state<=IDLE.
- Outputs:
  - sout_valid = (state==SHIFT).
  - frame_start = sout_valid && cnt==0.
  - frame_last = sout_valid && cnt==L-1.
  - In IDLE, sout=0.
- din is sampled only on an accept edge. Changes to din or din_valid at other times have no effect. A din_valid asserted mid-frame (din_ready=0) is not consumed; upstream must hold it.
- PARITY values other than 0, 1 or 2 are illegal. Behaviour for them is unspecified; a synthesis-time check is acceptable.

Test Plan:
- Reset, then din=8'b01110100 with din_valid for one cycle (MSB_FIRST=1, PARITY=0):
  - sout = 0,1,1,1,0,1,0,0 on 8 consecutive cycles, starting the cycle after accept.
  - frame_start on bit 0, frame_last on bit 7.
  - sout_valid then drops and din_ready=1.
- MSB_FIRST=0, din=8'b01000011 → sout = 1,1,0,0,0,0,1,0; sout_valid high for exactly 8 cycles.
- PARITY=1 with din=8'b01110100 → 9-bit frame whose bit 8 = 0; PARITY=2 with the same din → bit 8 = 1; frame_last on bit 8 in both cases.
- din_valid held high with din=8'b11100101, then din=8'b01010101 presented on the frame_last cycle:
  - 16 contiguous sout_valid cycles: 1,1,1,0,0,1,0,1,0,1,0,1,0,1,0,1.
  - frame_start on cycles 0 and 8; din_ready high only on cycles 7 and 15.
- din_valid asserted at bit 3 of a frame with din=8'b11010100 → not accepted (din_ready=0); current frame is unaffected; the word is accepted at the frame_last edge if still held.
- rst_n driven low during bit 4 of frame 8'b10101101 → after that edge: sout_valid=0, sout=0, frame_start=0, frame_last=0. After rst_n returns high, din_ready=1 and the next frame (8'b11110110) serializes fully and correctly.
